sprite_line_engine: RTL and testbench
=====================================

# sprite_line_engine

Sprite attribute store and per-scanline sprite evaluator that consumes the sprite write strobes produced by the CPU execute stage (`sprite_x`, `sprite_y`, `sprite_sel`, `sprite_pos`, `sprite_attr`, `sprite_vis`). It holds per-sprite position, tile and visibility. During each horizontal blank it scans the table for sprites on the next scanline. At pixel time it reports the winning sprite hit to the VGA pixel mixer.

## Interface
- `NUM_SPRITES`, 32, table entries; index width 5.
- `MAX_PER_LINE`, 4, sprites displayable per scanline.
- `SPR_SIZE`, 16, sprite width and height in pixels (power of 2).
- `V_TOTAL`, 525, total VGA lines per frame.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sprite_x` in 10: X position; also the data bus for attr/vis writes.
- `sprite_y` in 9: Y position.
- `sprite_sel` in 5: target sprite index.
- `sprite_pos` in 1: write strobe, x/y ← `sprite_x`/`sprite_y`.
- `sprite_attr` in 1: write strobe, tile ← `sprite_x[7:0]`.
- `sprite_vis` in 1: write strobe, vis ← `sprite_x[0]`.
- `hcount` in 10: current pixel column.
- `vcount` in 10: current line.
- `line_start` in 1: single-cycle pulse at the start of horizontal blank.
- `spr_hit` out 1: a sprite covers the current pixel.
- `spr_id` out 5: index of the winning sprite.
- `spr_tile` out 8: tile of the winning sprite.
- `spr_row` out 4: pixel row within the sprite.
- `spr_col` out 4: pixel column within the sprite.
- `spr_overflow` out 1: more than `MAX_PER_LINE` sprites landed on the displayed line.
- `eval_busy` out 1: evaluation scan in progress.

## Operation
- Table entry fields: x[9:0], y[8:0], tile[7:0], vis.
  - Register-based.
  - Writes take effect on the next clock edge.
  - Simultaneous strobes all apply to the same `sprite_sel` entry.
- FSM states: IDLE, SCAN, SWAP.
- IDLE → SCAN on `line_start`.
  - Latch target = `vcount`+1.
  - Target wraps to 0 when `vcount` = `V_TOTAL`−1.
  - Clear idx, clear the back-bank count and overflow.
- SCAN, one entry per cycle (idx 0..`NUM_SPRITES`−1):
  - Compute dy = target − {1'b0,y}, in 10-bit unsigned arithmetic.
  - Entry qualifies if vis=1 and dy < `SPR_SIZE`.
  - A qualifying entry with count < `MAX_PER_LINE` is pushed into the back bank as {id, x, row=dy[3:0], tile}; then count++.
  - A qualifying entry with count = `MAX_PER_LINE` sets back-bank overflow and is dropped.
  - At idx = `NUM_SPRITES`−1 go to SWAP.
- SWAP lasts one cycle:
  - The back bank becomes the display bank, including count and overflow.
  - Then return to IDLE.
- `line_start` during SCAN or SWAP:
  - Restarts the scan with a new target; the aborted back bank is discarded.
  - The display bank is unchanged.
- Table writes during SCAN: an entry already scanned keeps its old contribution. An unscanned entry uses the new value.
- Pixel match over the display-bank slots < count:
  - dx = `hcount` − x, in 10-bit unsigned arithmetic.
  - A slot hits if dx < `SPR_SIZE`.
  - Priority goes to the lowest slot, which is the lowest sprite index.
  - A winner drives `spr_hit`=1, `spr_id`, `spr_tile`, `spr_row`, and `spr_col`=dx[3:0].
  - With no hit, `spr_hit`=0 and the other outputs are 0.

## Timing
- Reset (async, `reset`=0):
  - All table entries 0, with vis=0.
  - Both banks empty; FSM in IDLE.
  - All outputs 0.
- Evaluation latency: SWAP occurs `NUM_SPRITES`+1 cycles after the `line_start` edge.
  - The display bank updates on the edge `NUM_SPRITES`+2 cycles after `line_start`.
  - Hblank (≥ 160 cycles) covers this.
- `eval_busy`=1 from the cycle after `line_start` through SWAP.
- Pixel outputs are registered, with 1-cycle latency from `hcount`.
- `spr_overflow` is registered and updates at SWAP.

## Test plan
- Single visible sprite:
  - Stimulus: sprite 3 at pos x=100, y=50; attr tile=0x2A; vis=1. Then `line_start` with `vcount`=54.
  - Response: after SWAP, driving `hcount`=107 gives, 1 cycle later, `spr_hit`=1, `spr_id`=3, `spr_tile`=0x2A, `spr_row`=5, `spr_col`=7.
  - Response: `hcount`=116 gives `spr_hit`=0.
- Visibility: same setup with vis=0 → `spr_hit`=0 for all `hcount`.
- Priority: sprites 2 and 7 both at x=40, y=10; `line_start` with `vcount`=9; `hcount`=45 → `spr_id`=2.
- Overflow: sprites 0–5 all at y=0 and visible; `line_start` with `vcount`=524 (target wraps to 0).
  - Response: sprites 0–3 hit at their x positions; sprites 4 and 5 never hit; `spr_overflow`=1.
  - Response: the next line with no sprites clears `spr_overflow` to 0.
- Abort and reset:
  - Stimulus: a second `line_start` 10 cycles into SCAN.
  - Response: `eval_busy` stays 1; the display bank updates `NUM_SPRITES`+2 cycles after the second pulse.
  - Stimulus: assert `reset` mid-scan.
  - Response: outputs 0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/sprite_line_engine.sv
// Sprite attribute table plus a per-scanline evaluator. It fills a back bank during hblank,
// swaps the back bank into the display bank, and reports the winning sprite for each pixel.
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_SIZE     = 16,
  parameter int V_TOTAL      = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sprite_x,
  input  logic [8:0] sprite_y,
  input  logic [4:0] sprite_sel,
  input  logic       sprite_pos,
  input  logic       sprite_attr,
  input  logic       sprite_vis,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       line_start,
  output logic       spr_hit,
  output logic [4:0] spr_id,
  output logic [7:0] spr_tile,
  output logic [3:0] spr_row,
  output logic [3:0] spr_col,
  output logic       spr_overflow,
  output logic       eval_busy
);

  localparam int IDX_W  = 5;
  localparam int SLOT_W = $clog2(MAX_PER_LINE);
  localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

  state_t state_q, state_d;

  logic [9:0] tbl_x_q    [NUM_SPRITES];
  logic [9:0] tbl_x_d    [NUM_SPRITES];
  logic [8:0] tbl_y_q    [NUM_SPRITES];
  logic [8:0] tbl_y_d    [NUM_SPRITES];
  logic [7:0] tbl_tile_q [NUM_SPRITES];
  logic [7:0] tbl_tile_d [NUM_SPRITES];
  logic       tbl_vis_q  [NUM_SPRITES];
  logic       tbl_vis_d  [NUM_SPRITES];

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       target_q, target_d;

  // One-entry read stage between the table and the qualify/push logic
  logic             stg_valid_q, stg_valid_d;
  logic             stg_last_q, stg_last_d;
  logic [IDX_W-1:0] stg_id_q, stg_id_d;
  logic [9:0]       stg_x_q, stg_x_d;
  logic [8:0]       stg_y_q, stg_y_d;
  logic [7:0]       stg_tile_q, stg_tile_d;
  logic             stg_vis_q, stg_vis_d;

  logic [IDX_W-1:0] bk_id_q   [MAX_PER_LINE];
  logic [IDX_W-1:0] bk_id_d   [MAX_PER_LINE];
  logic [9:0]       bk_x_q    [MAX_PER_LINE];
  logic [9:0]       bk_x_d    [MAX_PER_LINE];
  logic [3:0]       bk_row_q  [MAX_PER_LINE];
  logic [3:0]       bk_row_d  [MAX_PER_LINE];
  logic [7:0]       bk_tile_q [MAX_PER_LINE];
  logic [7:0]       bk_tile_d [MAX_PER_LINE];
  logic [CNT_W-1:0] bk_cnt_q, bk_cnt_d;
  logic             bk_ovf_q, bk_ovf_d;

  logic [IDX_W-1:0] dp_id_q   [MAX_PER_LINE];
  logic [IDX_W-1:0] dp_id_d   [MAX_PER_LINE];
  logic [9:0]       dp_x_q    [MAX_PER_LINE];
  logic [9:0]       dp_x_d    [MAX_PER_LINE];
  logic [3:0]       dp_row_q  [MAX_PER_LINE];
  logic [3:0]       dp_row_d  [MAX_PER_LINE];
  logic [7:0]       dp_tile_q [MAX_PER_LINE];
  logic [7:0]       dp_tile_d [MAX_PER_LINE];
  logic [CNT_W-1:0] dp_cnt_q, dp_cnt_d;
  logic             dp_ovf_q, dp_ovf_d;

  logic       hit_q, hit_d;
  logic [4:0] id_q, id_d;
  logic [7:0] tile_q, tile_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;

  logic [9:0] dy;
  logic       stg_qual;

  always_comb begin
    tbl_x_d    = tbl_x_q;
    tbl_y_d    = tbl_y_q;
    tbl_tile_d = tbl_tile_q;
    tbl_vis_d  = tbl_vis_q;
    if (sprite_pos) begin
      tbl_x_d[sprite_sel] = sprite_x;
      tbl_y_d[sprite_sel] = sprite_y;
    end
    if (sprite_attr) tbl_tile_d[sprite_sel] = sprite_x[7:0];
    if (sprite_vis)  tbl_vis_d[sprite_sel]  = sprite_x[0];
  end

  assign dy       = target_q - {1'b0, stg_y_q};
  assign stg_qual = stg_valid_q && stg_vis_q && (dy < 10'(SPR_SIZE));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    target_d    = target_q;
    stg_valid_d = stg_valid_q;
    stg_last_d  = stg_last_q;
    stg_id_d    = stg_id_q;
    stg_x_d     = stg_x_q;
    stg_y_d     = stg_y_q;
    stg_tile_d  = stg_tile_q;
    stg_vis_d   = stg_vis_q;
    bk_id_d     = bk_id_q;
    bk_x_d      = bk_x_q;
    bk_row_d    = bk_row_q;
    bk_tile_d   = bk_tile_q;
    bk_cnt_d    = bk_cnt_q;
    bk_ovf_d    = bk_ovf_q;
    dp_id_d     = dp_id_q;
    dp_x_d      = dp_x_q;
    dp_row_d    = dp_row_q;
    dp_tile_d   = dp_tile_q;
    dp_cnt_d    = dp_cnt_q;
    dp_ovf_d    = dp_ovf_q;

    case (state_q)
      SCAN: begin
        stg_valid_d = 1'b1;
        stg_last_d  = (idx_q == IDX_W'(NUM_SPRITES - 1));
        stg_id_d    = idx_q;
        stg_x_d     = tbl_x_q[idx_q];
        stg_y_d     = tbl_y_q[idx_q];
        stg_tile_d  = tbl_tile_q[idx_q];
        stg_vis_d   = tbl_vis_q[idx_q];
        idx_d       = idx_q + IDX_W'(1);
        if (stg_qual) begin
          if (bk_cnt_q < CNT_W'(MAX_PER_LINE)) begin
            bk_id_d[bk_cnt_q[SLOT_W-1:0]]   = stg_id_q;
            bk_x_d[bk_cnt_q[SLOT_W-1:0]]    = stg_x_q;
            bk_row_d[bk_cnt_q[SLOT_W-1:0]]  = dy[3:0];
            bk_tile_d[bk_cnt_q[SLOT_W-1:0]] = stg_tile_q;
            bk_cnt_d                        = bk_cnt_q + CNT_W'(1);
          end else begin
            bk_ovf_d = 1'b1;
          end
        end
        if (stg_valid_q && stg_last_q) begin
          state_d     = SWAP;
          stg_valid_d = 1'b0;
        end
      end
      SWAP: begin
        dp_id_d   = bk_id_q;
        dp_x_d    = bk_x_q;
        dp_row_d  = bk_row_q;
        dp_tile_d = bk_tile_q;
        dp_cnt_d  = bk_cnt_q;
        dp_ovf_d  = bk_ovf_q;
        state_d   = IDLE;
      end
      default: ;
    endcase

    // A new line_start always wins: restart the scan and leave the display bank alone
    if (line_start) begin
      state_d     = SCAN;
      target_d    = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      idx_d       = '0;
      stg_valid_d = 1'b0;
      stg_last_d  = 1'b0;
      bk_cnt_d    = '0;
      bk_ovf_d    = 1'b0;
      dp_id_d     = dp_id_q;
      dp_x_d      = dp_x_q;
      dp_row_d    = dp_row_q;
      dp_tile_d   = dp_tile_q;
      dp_cnt_d    = dp_cnt_q;
      dp_ovf_d    = dp_ovf_q;
    end
  end

  logic [9:0]              dx [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0] slot_hit;

  generate
    for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_slot
      assign dx[gi]       = hcount - dp_x_q[gi];
      assign slot_hit[gi] = (CNT_W'(gi) < dp_cnt_q) && (dx[gi] < 10'(SPR_SIZE));
    end
  endgenerate

  // Walk from the highest slot down so the lowest hitting slot is the last to assign
  always_comb begin
    hit_d  = 1'b0;
    id_d   = '0;
    tile_d = '0;
    row_d  = '0;
    col_d  = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_d  = 1'b1;
        id_d   = dp_id_q[i];
        tile_d = dp_tile_q[i];
        row_d  = dp_row_q[i];
        col_d  = dx[i][3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      target_q    <= '0;
      stg_valid_q <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_id_q    <= '0;
      stg_x_q     <= '0;
      stg_y_q     <= '0;
      stg_tile_q  <= '0;
      stg_vis_q   <= 1'b0;
      bk_cnt_q    <= '0;
      bk_ovf_q    <= 1'b0;
      dp_cnt_q    <= '0;
      dp_ovf_q    <= 1'b0;
      hit_q       <= 1'b0;
      id_q        <= '0;
      tile_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_x_q[i]    <= '0;
        tbl_y_q[i]    <= '0;
        tbl_tile_q[i] <= '0;
        tbl_vis_q[i]  <= 1'b0;
      end
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        bk_id_q[i]   <= '0;
        bk_x_q[i]    <= '0;
        bk_row_q[i]  <= '0;
        bk_tile_q[i] <= '0;
        dp_id_q[i]   <= '0;
        dp_x_q[i]    <= '0;
        dp_row_q[i]  <= '0;
        dp_tile_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
      stg_valid_q <= stg_valid_d;
      stg_last_q  <= stg_last_d;
      stg_id_q    <= stg_id_d;
      stg_x_q     <= stg_x_d;
      stg_y_q     <= stg_y_d;
      stg_tile_q  <= stg_tile_d;
      stg_vis_q   <= stg_vis_d;
      bk_cnt_q    <= bk_cnt_d;
      bk_ovf_q    <= bk_ovf_d;
      dp_cnt_q    <= dp_cnt_d;
      dp_ovf_q    <= dp_ovf_d;
      hit_q       <= hit_d;
      id_q        <= id_d;
      tile_q      <= tile_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tbl_x_q     <= tbl_x_d;
      tbl_y_q     <= tbl_y_d;
      tbl_tile_q  <= tbl_tile_d;
      tbl_vis_q   <= tbl_vis_d;
      bk_id_q     <= bk_id_d;
      bk_x_q      <= bk_x_d;
      bk_row_q    <= bk_row_d;
      bk_tile_q   <= bk_tile_d;
      dp_id_q     <= dp_id_d;
      dp_x_q      <= dp_x_d;
      dp_row_q    <= dp_row_d;
      dp_tile_q   <= dp_tile_d;
    end
  end

  assign spr_hit      = hit_q;
  assign spr_id       = id_q;
  assign spr_tile     = tile_q;
  assign spr_row      = row_q;
  assign spr_col      = col_q;
  assign spr_overflow = dp_ovf_q;
  assign eval_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: table-driven pixel checks per scenario,
// plus hand-written sequences for swap latency, scan abort and mid-scan reset.
module tb_sprite_line_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic [4:0] sprite_sel;
  logic       sprite_pos, sprite_attr, sprite_vis;
  logic [9:0] hcount, vcount;
  logic       line_start;
  logic       spr_hit;
  logic [4:0] spr_id;
  logic [7:0] spr_tile;
  logic [3:0] spr_row, spr_col;
  logic       spr_overflow, eval_busy;

  always #5 clk = ~clk;

  sprite_line_engine dut (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_sel(sprite_sel),
    .sprite_pos(sprite_pos), .sprite_attr(sprite_attr), .sprite_vis(sprite_vis),
    .hcount(hcount), .vcount(vcount), .line_start(line_start),
    .spr_hit(spr_hit), .spr_id(spr_id), .spr_tile(spr_tile),
    .spr_row(spr_row), .spr_col(spr_col),
    .spr_overflow(spr_overflow), .eval_busy(eval_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] pack_out();
    return {spr_hit, spr_id, spr_tile, spr_row, spr_col, spr_overflow};
  endfunction

  typedef struct {
    int         scen;
    string      name;
    logic [9:0] h;
    logic       hit;
    logic [4:0] id;
    logic [7:0] tile;
    logic [3:0] row;
    logic [3:0] col;
    logic       ovf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wr_pos(input logic [4:0] sel, input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    sprite_sel = sel; sprite_x = x; sprite_y = y; sprite_pos = 1'b1;
    @(negedge clk) sprite_pos = 1'b0;
  endtask

  task automatic wr_attr(input logic [4:0] sel, input logic [7:0] tile);
    @(negedge clk);
    sprite_sel = sel; sprite_x = {2'b00, tile}; sprite_attr = 1'b1;
    @(negedge clk) sprite_attr = 1'b0;
  endtask

  task automatic wr_vis(input logic [4:0] sel, input logic v);
    @(negedge clk);
    sprite_sel = sel; sprite_x = {9'd0, v}; sprite_vis = 1'b1;
    @(negedge clk) sprite_vis = 1'b0;
  endtask

  task automatic run_line(input logic [9:0] v);
    int n;
    @(negedge clk);
    line_start = 1'b1; vcount = v;
    @(negedge clk) line_start = 1'b0;
    n = 0;
    while (eval_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("line_done", 32'(eval_busy), 32'd0);
  endtask

  task automatic setup_scen(input int s);
    case (s)
      0: begin
        do_reset();
        wr_pos(5'd3, 10'd100, 9'd50); wr_attr(5'd3, 8'h2A); wr_vis(5'd3, 1'b1);
        run_line(10'd54);
      end
      1: begin
        do_reset();
        wr_pos(5'd3, 10'd100, 9'd50); wr_attr(5'd3, 8'h2A);
        wr_vis(5'd3, 1'b1); wr_vis(5'd3, 1'b0);
        run_line(10'd54);
      end
      2: begin
        do_reset();
        wr_pos(5'd2, 10'd40, 9'd10); wr_attr(5'd2, 8'h11); wr_vis(5'd2, 1'b1);
        wr_pos(5'd7, 10'd40, 9'd10); wr_attr(5'd7, 8'h77); wr_vis(5'd7, 1'b1);
        run_line(10'd9);
      end
      3: begin
        do_reset();
        for (int i = 0; i < 6; i++) begin
          wr_pos(5'(i), 10'(200 + 20 * i), 9'd0);
          wr_attr(5'(i), 8'(160 + i));
          wr_vis(5'(i), 1'b1);
        end
        run_line(10'd524);
      end
      default: run_line(10'd300);
    endcase
  endtask

  initial begin
    bit busy_ok;

    vecs[0]  = '{0, "s0_inside",   10'd107, 1'b1, 5'd3, 8'h2A, 4'd5, 4'd7,  1'b0};
    vecs[1]  = '{0, "s0_right",    10'd116, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[2]  = '{0, "s0_leftedge", 10'd100, 1'b1, 5'd3, 8'h2A, 4'd5, 4'd0,  1'b0};
    vecs[3]  = '{0, "s0_rightcol", 10'd115, 1'b1, 5'd3, 8'h2A, 4'd5, 4'd15, 1'b0};
    vecs[4]  = '{0, "s0_left",     10'd99,  1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[5]  = '{1, "s1_invis_a",  10'd107, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[6]  = '{1, "s1_invis_b",  10'd100, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[7]  = '{2, "s2_prio",     10'd45,  1'b1, 5'd2, 8'h11, 4'd0, 4'd5,  1'b0};
    vecs[8]  = '{2, "s2_prio_end", 10'd55,  1'b1, 5'd2, 8'h11, 4'd0, 4'd15, 1'b0};
    vecs[9]  = '{2, "s2_past",     10'd56,  1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[10] = '{3, "s3_spr0",     10'd200, 1'b1, 5'd0, 8'hA0, 4'd0, 4'd0,  1'b1};
    vecs[11] = '{3, "s3_spr1",     10'd225, 1'b1, 5'd1, 8'hA1, 4'd0, 4'd5,  1'b1};
    vecs[12] = '{3, "s3_spr2",     10'd240, 1'b1, 5'd2, 8'hA2, 4'd0, 4'd0,  1'b1};
    vecs[13] = '{3, "s3_spr3",     10'd275, 1'b1, 5'd3, 8'hA3, 4'd0, 4'd15, 1'b1};
    vecs[14] = '{3, "s3_spr4",     10'd280, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b1};
    vecs[15] = '{3, "s3_spr5",     10'd305, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b1};
    vecs[16] = '{4, "s4_ovf_clr",  10'd200, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};
    vecs[17] = '{4, "s4_empty",    10'd240, 1'b0, 5'd0, 8'h00, 4'd0, 4'd0,  1'b0};

    reset = 1'b0;
    sprite_x = '0; sprite_y = '0; sprite_sel = '0;
    sprite_pos = 1'b0; sprite_attr = 1'b0; sprite_vis = 1'b0;
    hcount = '0; vcount = '0; line_start = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({pack_out(), eval_busy}), 32'd0);
    reset = 1'b1;

    for (int s = 0; s < 5; s++) begin
      setup_scen(s);
      for (int v = 0; v < NV; v++) begin
        if (vecs[v].scen == s) begin
          @(negedge clk) hcount = vecs[v].h;
          @(negedge clk);
          $display("vec %-12s hcount=%0d hit=%0b id=%0d tile=%02h row=%0d col=%0d ovf=%0b",
                   vecs[v].name, vecs[v].h, spr_hit, spr_id, spr_tile, spr_row, spr_col,
                   spr_overflow);
          check(vecs[v].name, 32'(pack_out()),
                32'({vecs[v].hit, vecs[v].id, vecs[v].tile, vecs[v].row, vecs[v].col,
                     vecs[v].ovf}));
        end
      end
    end

    // Swap latency: display overflow flips on the edge 34 cycles after line_start
    @(negedge clk);
    line_start = 1'b1; vcount = 10'd524;
    @(negedge clk) line_start = 1'b0;
    busy_ok = eval_busy;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (!eval_busy) busy_ok = 1'b0;
    end
    check("lat_busy_held", 32'(busy_ok), 32'd1);
    check("lat_ovf_before_swap", 32'(spr_overflow), 32'd0);
    @(negedge clk);
    check("lat_ovf_at_swap", 32'(spr_overflow), 32'd1);
    check("lat_busy_done", 32'(eval_busy), 32'd0);
    $display("seq latency ovf=%0b busy=%0b", spr_overflow, eval_busy);

    // Abort: second line_start 10 cycles in retargets to an empty line
    @(negedge clk);
    line_start = 1'b1; vcount = 10'd524;
    @(negedge clk) line_start = 1'b0;
    busy_ok = eval_busy;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (!eval_busy) busy_ok = 1'b0;
    end
    line_start = 1'b1; vcount = 10'd300;
    @(negedge clk) line_start = 1'b0;
    for (int k = 11; k <= 43; k++) begin
      if (!eval_busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    if (!eval_busy) busy_ok = 1'b0;
    check("abort_busy_held", 32'(busy_ok), 32'd1);
    check("abort_ovf_held", 32'(spr_overflow), 32'd1);
    @(negedge clk);
    check("abort_ovf_swapped", 32'(spr_overflow), 32'd0);
    check("abort_busy_done", 32'(eval_busy), 32'd0);
    $display("seq abort ovf=%0b busy=%0b", spr_overflow, eval_busy);

    // Reset mid-scan clears outputs without waiting for a clock edge
    run_line(10'd524);
    @(negedge clk) hcount = 10'd200;
    @(negedge clk);
    check("pre_reset_hit", 32'(pack_out()), 32'({1'b1, 5'd0, 8'hA0, 4'd0, 4'd0, 1'b1}));
    line_start = 1'b1; vcount = 10'd524;
    @(negedge clk) line_start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_async", 32'({pack_out(), eval_busy}), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'({pack_out(), eval_busy}), 32'd0);
    $display("seq reset hit=%0b busy=%0b", spr_hit, eval_busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
